// File: rtl/stack_host_pkg.sv
// stack_host_pkg
// Shared definitions for the stack_host block: FSM state encoding, stack
// data width, default stack depth and the Stk_PushPop encoding.
package stack_host_pkg;

  localparam int STK_DATA_W    = 8;
  localparam int DEPTH_DEFAULT = 1024;

  // Stk_PushPop encoding seen by the attached Stack.
  localparam logic STK_PUSH = 1'b1;
  localparam logic STK_POP  = 1'b0;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/stack_host_if.sv
// stack_host_if
// Client-side streaming interface of stack_host.
//   Upstream   : In_Data, In_Valid -> host ; In_Ready <- host
//   Control    : Flush -> host ; Done <- host (one-cycle drain-complete pulse)
//   Downstream : Out_Data, Out_Valid <- host ; Out_Ready -> host
//   Status     : Level (bytes held in the stack), Error (sticky check flag)
// Modports: slave = stack_host side, master = client side.
interface stack_host_if #(
  parameter int LVL_W = 11
);
  import stack_host_pkg::*;

  logic [STK_DATA_W-1:0] In_Data;
  logic                  In_Valid;
  logic                  In_Ready;
  logic                  Flush;
  logic [STK_DATA_W-1:0] Out_Data;
  logic                  Out_Valid;
  logic                  Out_Ready;
  logic                  Done;
  logic [LVL_W-1:0]      Level;
  logic                  Error;

  modport master (
    output In_Data, In_Valid, Flush, Out_Ready,
    input  In_Ready, Out_Data, Out_Valid, Done, Level, Error
  );

  modport slave (
    input  In_Data, In_Valid, Flush, Out_Ready,
    output In_Ready, Out_Data, Out_Valid, Done, Level, Error
  );

endinterface

// File: rtl/stack_io_buf.sv
// stack_io_buf
// Tri-state driver for the shared Stack IO bus. This is the only place in
// the block that touches an inout.
//   oe_i   : drive enable (high only during push cycles)
//   data_i : byte to drive onto the bus
//   data_o : resolved bus value (whatever the Stack drives during a pop)
//   pad_io : the shared bus
module stack_io_buf
  import stack_host_pkg::*;
(
  input  logic                  oe_i,
  input  logic [STK_DATA_W-1:0] data_i,
  output logic [STK_DATA_W-1:0] data_o,
  inout  wire  [STK_DATA_W-1:0] pad_io
);

  assign pad_io = oe_i ? data_i : {STK_DATA_W{1'bz}};
  assign data_o = pad_io;

endmodule

// File: rtl/stack_host.sv
// stack_host
// Bus master for an 8-bit LIFO Stack. Bytes arriving on the upstream
// valid/ready stream are pushed onto the stack; a Flush request pops the
// stack empty into the downstream stream (reverse order), then pulses Done.
// Ports:
//   Clk, Reset  : clock, asynchronous active-high reset (shared with Stack)
//   bus         : stack_host_if.slave (In_*, Flush, Out_*, Done, Level, Error)
//   Stk_IO      : shared tri-state data bus to Stack.IO
//   Stk_PushPop : 1 = push, 0 = pop
//   Stk_Enable  : stack operation strobe
//   Stk_Full, Stk_Empty : registered stack status
// Optional feature: define STACK_HOST_CHECK_EN to enable the sticky protocol
// checker driving Error; otherwise Error is tied low.
module stack_host
  import stack_host_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  stack_host_if.slave           bus,
  inout  wire  [STK_DATA_W-1:0] Stk_IO,
  output logic                  Stk_PushPop,
  output logic                  Stk_Enable,
  input  logic                  Stk_Full,
  input  logic                  Stk_Empty
);

  localparam logic [0:0] ST_FILL  = FILL;
  localparam logic [0:0] ST_DRAIN = DRAIN;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  logic [0:0]            state_q, state_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [STK_DATA_W-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;

  logic                  push;
  logic                  pop;
  logic                  drain_end;
  logic [STK_DATA_W-1:0] stk_rd_data;

  // Strobes are gated by Reset so the bus stays released and no stack
  // operation is requested while the shared reset is asserted.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    drain_end = 1'b0;
    if (!Reset) begin
      if (state_q == ST_FILL) begin
        push = bus.In_Valid & ~Stk_Full;
      end else begin
        // Only pop when the output register is free or being emptied now.
        pop       = ~Stk_Empty & (~out_valid_q | bus.Out_Ready);
        drain_end =  Stk_Empty & (~out_valid_q | bus.Out_Ready);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    if (state_q == ST_FILL) begin
      // A push in the same cycle as Flush still completes (push is independent).
      if (bus.Flush) state_d = ST_DRAIN;
    end else if (drain_end) begin
      state_d = ST_FILL;
      done_d  = 1'b1;
    end

    if (push && (level_q != LVL_MAX)) level_d = level_q + LVL_W'(1);
    if (pop  && (level_q != '0))      level_d = level_q - LVL_W'(1);

    if (pop) begin
      out_data_d  = stk_rd_data;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.Out_Ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_FILL;
      level_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  stack_io_buf u_io_buf (
    .oe_i   (push),
    .data_i (bus.In_Data),
    .data_o (stk_rd_data),
    .pad_io (Stk_IO)
  );

  assign Stk_Enable    = push | pop;
  assign Stk_PushPop   = push ? STK_PUSH : STK_POP;
  assign bus.In_Ready  = ~Reset & (state_q == ST_FILL) & ~Stk_Full;
  assign bus.Out_Data  = out_data_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Done      = done_q;
  assign bus.Level     = level_q;

`ifdef STACK_HOST_CHECK_EN
  logic             error_q, error_d;
  logic [LVL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall;

  // stall_cnt_q counts consecutive stalled cycles before the current one;
  // reaching DEPTH while still stalled means more than DEPTH stalled cycles.
  always_comb begin
    stall       = (state_q == ST_FILL) & bus.In_Valid & Stk_Full;
    stall_cnt_d = '0;
    if (stall) stall_cnt_d = (stall_cnt_q == LVL_MAX) ? stall_cnt_q : stall_cnt_q + LVL_W'(1);
    error_d = error_q;
    if (((level_q == '0) != Stk_Empty) ||
        ((level_q == LVL_MAX) != Stk_Full) ||
        (stall && (stall_cnt_q == LVL_MAX))) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      error_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      error_q     <= error_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.Error = error_q;
`else
  assign bus.Error = 1'b0;
`endif

endmodule

// File: doc/stack_host.md
# stack_host

Bus master for the 8-bit LIFO `Stack`, the initiator side of its `IO`/`Push_Pop`/`Enable`/`Full`/`Empty` interface. It accepts bytes from an upstream valid/ready stream and pushes them onto the stack. On a `Flush` request it pops the stack empty into a downstream valid/ready stream, delivering the bytes in reverse order. It sits between the byte source and the stack so that no other logic ever drives the shared tri-state `IO` bus.

## Interface
- `DEPTH`, 1024: stack capacity in bytes. Must match the attached `Stack`.
- `LVL_W`, 11: width of `Level`, equal to clog2(DEPTH)+1.

Ports (clock and reset first):
- `Clk`  in  1  sole clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high; the same net also resets the attached `Stack`.
- `In_Data`  in  8  upstream byte.
- `In_Valid`  in  1  upstream byte present.
- `In_Ready`  out  1  byte accepted this cycle when high together with `In_Valid`.
- `Flush`  in  1  one-cycle request to drain the stack.
- `Out_Data`  out  8  popped byte, registered.
- `Out_Valid`  out  1  `Out_Data` holds a valid byte.
- `Out_Ready`  in  1  downstream accepts the byte.
- `Done`  out  1  one-cycle pulse when a drain completes.
- `Level`  out  `LVL_W`  bytes currently held in the stack.
- `Error`  out  1  sticky protocol-check flag (see Configuration).
- `Stk_IO`  inout  8  shared data bus to `Stack.IO`.
- `Stk_PushPop`  out  1  1 = push, 0 = pop.
- `Stk_Enable`  out  1  stack operation strobe.
- `Stk_Full`  in  1  from `Stack.Full`.
- `Stk_Empty`  in  1  from `Stack.Empty`.

## Operation
- The FSM has two states, FILL and DRAIN. Reset state is FILL.
- Reset values: `Out_Valid`=0, `Out_Data`=0, `Done`=0, `Level`=0, `Error`=0, `Stk_Enable`=0, `Stk_PushPop`=0, `Stk_IO`=Z.
- FILL:
  - `In_Ready` = `~Stk_Full`.
  - On the push handshake (`In_Valid & In_Ready`): `Stk_Enable`=1, `Stk_PushPop`=1, and `Stk_IO` is driven with `In_Data`, all combinationally. `Level` increments at the edge.
  - `Flush` sampled high moves the FSM to DRAIN at the next edge. If a push handshake occurs in the same cycle, that push completes first.
- DRAIN:
  - `In_Ready`=0.
  - A pop is issued when `~Stk_Empty & (~Out_Valid | Out_Ready)`. During the pop: `Stk_Enable`=1, `Stk_PushPop`=0, `Stk_IO`=Z.
  - At that edge `Stk_IO` is captured into `Out_Data`, `Out_Valid` is set, and `Level` decrements.
  - When `Out_Ready & Out_Valid` and no pop is issued, `Out_Valid` clears.
  - When `Stk_Empty` is high and either `Out_Valid`=0 or the final byte is accepted this cycle: pulse `Done` and return to FILL.
  - `Flush` is ignored while in DRAIN.
- `Stk_IO` is driven only during push cycles and is high-Z at all other times, including during reset.
- `Level` saturates at 0 and at `DEPTH`; it never wraps.

## Timing
- Push latency: the byte is written at the handshake edge, with zero wait states.
- Pop latency: `Out_Valid` rises one cycle after the pop strobe.
- Throughput: one byte per cycle in both directions when `In_Valid` or `Out_Ready` is held high.
- `Flush` to first pop: 1 cycle.
- A drain of N bytes with `Out_Ready` held high takes N+1 cycles from entering DRAIN to the `Done` pulse.
- An asserted `Reset` mid-drain aborts immediately. The byte held in `Out_Data` is discarded and no `Done` pulse is produced.
- `Stk_Full` and `Stk_Empty` are treated as registered stack state valid for the whole cycle.

## Configuration
- `STACK_HOST_CHECK_EN` defined: `Error` sets and stays set until `Reset` when any of these occurs:
  - `(Level==0) != Stk_Empty`
  - `(Level==DEPTH) != Stk_Full`
  - `In_Valid` is held while `Stk_Full` for more than DEPTH cycles in FILL (stall watchdog)
- `STACK_HOST_CHECK_EN` undefined: `Error` is tied to 0 and the check logic is absent.

## Structure
- Package `stack_host_pkg` holds:
  - the state enum (FILL, DRAIN)
  - `STK_DATA_W`=8
  - the default `DEPTH`
  - the push/pop encoding constants (`STK_PUSH`=1, `STK_POP`=0)
- One sub-module, `stack_io_buf`, is the 8-bit tri-state driver for `Stk_IO`. It takes a drive-enable and data and returns the sampled bus value. All `inout` handling is isolated there.

## Test plan
- Push 0x11, 0x22, 0x33, then `Flush` with `Out_Ready`=1 → `Out_Data` sequence 0x33, 0x22, 0x11 on consecutive cycles; `Done` one cycle after the last byte; `Level` 3→0.
- Fill DEPTH=1024 bytes → `Stk_Full`=1, `In_Ready`=0, `Level`=1024. The 1025th `In_Valid` is held off and no `Stk_Enable` pulse is issued.
- `Flush` on an empty stack → `Done` pulses 1 cycle after DRAIN is entered; no `Stk_Enable`; `Out_Valid` stays 0.
- Drain 4 bytes with `Out_Ready` toggling 1,0,0,1,… → no byte is lost or duplicated, `Out_Data` is stable while stalled, and no pop occurs while `Out_Valid & ~Out_Ready`.
- `Reset` asserted mid-drain after 2 of 5 bytes → all outputs take their reset values asynchronously, `Stk_IO`=Z, FSM in FILL; a new push of 0xA5 then `Flush` returns 0xA5.
- With `STACK_HOST_CHECK_EN`: force `Stk_Empty`=1 while `Level`=2 → `Error`=1 next edge and it stays set until `Reset`.
